// File: rtl/iram_pkg.sv
// Shared types for the instruction memory loader.
// Also holds the opcode and bus-select codes used by the control unit.
package iram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_JZ   = 4'd10;
  localparam logic [3:0] OP_OVER = 4'd15;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

endpackage

// File: rtl/iram_loader_if.sv
// Fetch and byte-load bus of the instruction memory.
// master = core/loader side, slave = memory side.
interface iram_loader_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WORD_W-1:0] fetch_word;
  logic              fetch_valid;
  logic              fetch_err;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [BYTE_W-1:0] load_byte;
  logic              load_byte_valid;
  logic              load_last;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] load_count;
  logic              core_run;

  modport master (
    output fetch_req, fetch_addr,
    output load_start, load_base, load_byte,
    output load_byte_valid, load_last,
    input  fetch_word, fetch_valid, fetch_err,
    input  load_busy, load_done, load_err,
    input  load_count, core_run
  );

  modport slave (
    input  fetch_req, fetch_addr,
    input  load_start, load_base, load_byte,
    input  load_byte_valid, load_last,
    output fetch_word, fetch_valid, fetch_err,
    output load_busy, load_done, load_err,
    output load_count, core_run
  );
endinterface

// File: rtl/iram_word_assembler.sv
// Collects bytes big-endian into a word.
// A last byte zero-pads the remaining low bytes.
module iram_word_assembler #(
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_last,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);
  localparam int NB = WORD_W / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] merged;

  // Merge incoming byte, pad, and pick next shift state
  always_comb begin
    merged = (shreg_q << BYTE_W) | WORD_W'(byte_in);
    word = merged << (BYTE_W * (NB - 1 - int'(idx_q)));
    word_ready = byte_valid && (byte_last || idx_q == LAST_IDX);
    shreg_d = shreg_q;
    idx_d = idx_q;
    if (clear || word_ready) begin
      shreg_d = '0;
      idx_d = '0;
    end else if (byte_valid) begin
      shreg_d = merged;
      idx_d = idx_q + 1'b1;
    end
  end

  // Shift register and byte index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/iram_loader.sv
// Instruction memory with byte-serial program load
// and a pipelined one-cycle fetch port gated until RUN.
module iram_loader
  import iram_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16,
  parameter int BYTE_W = 8
) (
  input logic clk,
  input logic rst_n,
  iram_loader_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              run_q, run_d;
  logic [WORD_W-1:0] fword_q, fword_d;
  logic              fvalid_q, fvalid_d;
  logic              ferr_q, ferr_d;

  logic              accept;
  logic              asm_ready;
  logic [WORD_W-1:0] asm_word;
  logic              wr_ok;
  logic              rd_ok;

  logic [WORD_W-1:0] mem [DEPTH];

  assign accept = (state_q == ST_LOAD) && bus.load_byte_valid
                  && !bus.load_start;
  assign wr_ok = {1'b0, ptr_q} < DEPTH_X;
  assign rd_ok = {1'b0, bus.fetch_addr} < DEPTH_X;

  iram_word_assembler #(
    .WORD_W(WORD_W),
    .BYTE_W(BYTE_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.load_start),
    .byte_valid(accept),
    .byte_in   (bus.load_byte),
    .byte_last (bus.load_last),
    .word_ready(asm_ready),
    .word      (asm_word)
  );

  // Next state, load bookkeeping and fetch response
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    count_d = count_q;
    err_d = err_q;
    done_d = 1'b0;
    if (bus.load_start) begin
      state_d = ST_LOAD;
      ptr_d = bus.load_base;
      count_d = '0;
      err_d = 1'b0;
    end else if (asm_ready) begin
      ptr_d = (ptr_q == '1) ? ptr_q : ptr_q + 1'b1;
      if (wr_ok) count_d = count_q + 1'b1;
      else err_d = 1'b1;
      if (bus.load_last) begin
        state_d = ST_RUN;
        done_d = 1'b1;
      end
    end
    busy_d = (state_d == ST_LOAD);
    run_d = (state_d == ST_RUN);
    fvalid_d = (state_q == ST_RUN) && bus.fetch_req;
    fword_d = '0;
    ferr_d = 1'b0;
    if (fvalid_d) begin
      if (rd_ok) fword_d = mem[bus.fetch_addr[AW-1:0]];
      else ferr_d = 1'b1;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      run_q <= 1'b0;
      fword_q <= '0;
      fvalid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      count_q <= count_d;
      err_q <= err_d;
      done_q <= done_d;
      busy_q <= busy_d;
      run_q <= run_d;
      fword_q <= fword_d;
      fvalid_q <= fvalid_d;
      ferr_q <= ferr_d;
    end
  end

  // Program storage; not reset so a program survives rst_n
  always_ff @(posedge clk) begin
    if (asm_ready && wr_ok) mem[ptr_q[AW-1:0]] <= asm_word;
  end

  assign bus.fetch_word = fword_q;
  assign bus.fetch_valid = fvalid_q;
  assign bus.fetch_err = ferr_q;
  assign bus.load_busy = busy_q;
  assign bus.load_done = done_q;
  assign bus.load_err = err_q;
  assign bus.load_count = count_q;
  assign bus.core_run = run_q;
endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: byte loads, then fetches
// checked against a scoreboard of expected responses.
module tb_iram_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  iram_loader_if #(.ADDR_W(16), .WORD_W(16), .BYTE_W(8)) bus ();

  iram_loader #(
    .DEPTH(512), .WORD_W(16), .ADDR_W(16), .BYTE_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  logic [15:0] exp_mem [512];
  logic [16:0] sb [$];
  logic [7:0] ld_bytes [$];
  int fa [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Fetch response monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && (bus.fetch_valid || bus.fetch_err)) begin
      logic [16:0] e;
      n_valid++;
      check("err_needs_valid", {31'd0, bus.fetch_valid}, 32'd1);
      if (sb.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("fetch_word", {16'd0, bus.fetch_word}, {16'd0, e[15:0]});
        check("fetch_err", {31'd0, bus.fetch_err}, {31'd0, e[16]});
      end
    end
  end

  task automatic do_load(input int base);
    int ptr, idx, cnt, n;
    logic [15:0] w;
    logic er;
    n = ld_bytes.size();
    ptr = base; idx = 0; cnt = 0; er = 1'b0; w = '0;
    for (int i = 0; i < n; i++) begin
      w = (w << 8) | {8'h00, ld_bytes[i]};
      idx++;
      if (idx == 2 || i == n - 1) begin
        w = w << (8 * (2 - idx));
        if (ptr < 512) begin
          exp_mem[ptr] = w;
          cnt++;
        end else begin
          er = 1'b1;
        end
        ptr++; idx = 0; w = '0;
      end
    end
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_base = 16'(base);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    check("busy_in_load", {31'd0, bus.load_busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      bus.load_byte_valid = 1'b1;
      bus.load_byte = ld_bytes[i];
      bus.load_last = (i == n - 1);
      @(posedge clk); #1;
    end
    bus.load_byte_valid = 1'b0;
    bus.load_last = 1'b0;
    check("load_done", {31'd0, bus.load_done}, 32'd1);
    check("core_run", {31'd0, bus.core_run}, 32'd1);
    check("busy_after", {31'd0, bus.load_busy}, 32'd0);
    check("load_count", {16'd0, bus.load_count}, 32'(cnt));
    check("load_err", {31'd0, bus.load_err}, {31'd0, er});
    @(posedge clk); #1;
    check("done_pulse", {31'd0, bus.load_done}, 32'd0);
  endtask

  task automatic do_fetch();
    for (int i = 0; i < fa.size(); i++) begin
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 16'(fa[i]);
      if (fa[i] < 512) sb.push_back({1'b0, exp_mem[fa[i]]});
      else sb.push_back({1'b1, 16'h0000});
      @(posedge clk); #1;
    end
    bus.fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int v0;
    for (int i = 0; i < 512; i++) exp_mem[i] = '0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_base = '0;
    bus.load_byte = '0;
    bus.load_byte_valid = 1'b0;
    bus.load_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_word", {16'd0, bus.fetch_word}, 32'd0);
    check("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check("rst_ferr", {31'd0, bus.fetch_err}, 32'd0);
    check("rst_busy", {31'd0, bus.load_busy}, 32'd0);
    check("rst_done", {31'd0, bus.load_done}, 32'd0);
    check("rst_lerr", {31'd0, bus.load_err}, 32'd0);
    check("rst_count", {16'd0, bus.load_count}, 32'd0);
    check("rst_run", {31'd0, bus.core_run}, 32'd0);

    v0 = n_valid;
    bus.fetch_req = 1'b1;
    bus.fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1 bus.fetch_req = 1'b0;
    @(posedge clk); #1;
    check("idle_no_fetch", 32'(n_valid - v0), 32'd0);

    ld_bytes = '{8'h28, 8'h40, 8'h04, 8'hD3};
    do_load(0);
    fa = '{1};
    do_fetch();

    ld_bytes = '{8'hAB, 8'hCD, 8'hEF};
    do_load(10);
    fa = '{10, 11};
    do_fetch();

    ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(511);
    fa = '{511, 600};
    do_fetch();

    fa = '{0, 1, 10};
    do_fetch();

    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_base = '0;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.load_byte_valid = 1'b1;
    bus.load_byte = 8'h99;
    @(posedge clk); #1;
    bus.load_byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.load_busy}, 32'd0);
    check("midrst_run", {31'd0, bus.core_run}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    ld_bytes = '{8'h55, 8'h66};
    do_load(20);
    fa = '{0, 20, 1};
    do_fetch();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iram_loader.md
# iram_loader

Parametrised successor to the instruction memory for the down-sampler processor core. It holds the program and is written at run time through a byte-serial load port, for example from the UART receiver, so no initial block is needed. The core fetches through a synchronous-read port with a one-cycle request/valid handshake. A small state machine gates fetches until a program has been loaded.

## Interface
- `DEPTH`, default 512: number of instruction words.
- `WORD_W`, default 16: instruction word width. Must be a multiple of `BYTE_W`.
- `ADDR_W`, default 16: width of the fetch and load address ports, equal to the PC width.
- `BYTE_W`, default 8: load-port byte width.
- Reset is asynchronous and active-low. The block has one clock, `clk`.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `fetch_req`, in, 1: fetch request from the core.
- `fetch_addr`, in, `ADDR_W`: fetch word address.
- `fetch_word`, out, `WORD_W`: fetched instruction.
- `fetch_valid`, out, 1: `fetch_word` is valid this cycle.
- `fetch_err`, out, 1: the returned fetch was out of range.
- `load_start`, in, 1: begin a program load.
- `load_base`, in, `ADDR_W`: first word address of the load. Sampled together with `load_start`.
- `load_byte`, in, `BYTE_W`: load data.
- `load_byte_valid`, in, 1: `load_byte` is present this cycle.
- `load_last`, in, 1: marks the final byte of the load. Qualified by `load_byte_valid`.
- `load_busy`, out, 1: high while in LOAD. The core must hold while this is high.
- `load_done`, out, 1: one-cycle pulse at the end of a load.
- `load_err`, out, 1: sticky flag; at least one word fell outside the memory.
- `load_count`, out, `ADDR_W`: number of words written by the current or most recent load.
- `core_run`, out, 1: high in RUN.

## Operation
- **States and transitions:**
  - IDLE, LOAD, RUN; reset enters IDLE.
  - IDLE or RUN with `load_start` → LOAD.
  - LOAD with `load_start` → restart of LOAD (pointer reloaded, partial word discarded, count and error cleared).
  - LOAD with an accepted byte carrying `load_last` → RUN.
- **Entering LOAD:**
  - The word pointer takes `load_base`.
  - The byte index, `load_count` and `load_err` are cleared.
- **Byte acceptance:**
  - In LOAD, each cycle with `load_byte_valid` accepts one byte. The first byte of a word goes to the MSBs (big-endian).
  - When `WORD_W/BYTE_W` bytes have been collected, the assembled word is written to the pointer address. The pointer increments and `load_count` increments.
- **Last byte:**
  - If the final byte leaves a partial word, the remaining low bytes are zero-padded and the word is written.
- **Out-of-range writes:**
  - A write with pointer ≥ `DEPTH` is dropped and sets `load_err`. `load_count` does not increment.
  - The pointer does not wrap.
- **Simultaneous events:**
  - If `load_start` and `load_byte_valid` arrive in the same cycle, `load_start` wins and the byte is dropped.
  - `load_byte_valid` outside LOAD is ignored.
- **Fetch:**
  - Honoured only in RUN.
  - In range: `fetch_word` returns the memory contents at `fetch_addr`.
  - `fetch_addr` ≥ `DEPTH`: `fetch_word` is 0 and `fetch_err` is 1.
  - In IDLE or LOAD, `fetch_req` is ignored.
- **Memory contents:** the memory array has no reset. Contents survive `rst_n`; simulation initialises the array to 0.

## Timing
- **Reset values:**
  - `fetch_word` = 0; `fetch_valid`, `fetch_err`, `load_busy`, `load_done`, `load_err` and `core_run` = 0; `load_count` = 0.
  - The byte assembler and pointer are also cleared.
- **Fetch latency:**
  - A request sampled at edge N gives `fetch_valid` high for the cycle after edge N, with data registered at edge N.
  - Requests may be issued every cycle and are fully pipelined.
  - Each of `fetch_valid` and `fetch_err` is high for exactly one cycle per request.
- **In-flight fetch:** if `load_start` arrives in the same cycle as a RUN fetch, that fetch still completes on the next cycle.
- **Write timing:** a word is written on the same edge that accepts its final byte.
- **End of load:**
  - On the edge accepting the `load_last` byte, the state moves to RUN. `load_done` and `core_run` are high from the following cycle.
  - A fetch in the first RUN cycle returns the just-written data.
- **`load_busy`:** registered; high exactly in the cycles in which the state is LOAD.
- **Reset mid-load:** returns to IDLE. The partial word is discarded and already-written words are retained.

## Structure
- **Package `iram_pkg`:**
  - State enum (IDLE, LOAD, RUN).
  - The opcode constants (ADD … OVER) and the A/B/C bus select codes shared with the control unit.
- **Sub-module `iram_word_assembler`:**
  - Byte shift register plus byte index.
  - Zero-pad on last.
  - Outputs `word_ready` and `word`.
- **Top level:** the state machine, pointer, counters, memory array and fetch pipeline register.

## Test plan
Defaults: `DEPTH`=512, `WORD_W`=16, `BYTE_W`=8.
- **Reset:** reset, then `fetch_req` with address 0 in IDLE → all outputs 0, `fetch_valid` never asserts.
- **Basic load and fetch:** `load_start` with base 0, bytes 0x28, 0x40, 0x04, 0xD3 (last) → `load_done` pulse, `load_count`=2, mem[0]=0x2840, mem[1]=0x04D3. Then fetch address 1 → next cycle `fetch_valid`=1, `fetch_word`=0x04D3.
- **Partial word:** base 10, bytes 0xAB, 0xCD, 0xEF (last) → mem[10]=0xABCD, mem[11]=0xEF00, `load_count`=2.
- **Overflow and out-of-range fetch:**
  - Base 511, bytes 0x11, 0x22, 0x33, 0x44 (last) → mem[511]=0x1122, second word dropped, `load_err`=1, `load_count`=1.
  - Fetch address 600 → `fetch_valid`=1, `fetch_err`=1, `fetch_word`=0.
- **Back-to-back fetch:** fetch addresses 0, 1, 10 on consecutive cycles → three consecutive valid cycles returning 0x2840, 0x04D3, 0xABCD.
- **Reset mid-load:** assert `rst_n` low after 1 byte of a load at base 0 → IDLE, `load_busy`=0. After reloading only base 20 with 0x55, 0x66 (last), mem[0] is still 0x2840.
